// File: rtl/encoder_8_to_3_seq.sv
// encoder_8_to_3_seq: captures the index of the highest-priority set request
// bit, holds it with VALID until acknowledged, then waits for the request to
// drop before it re-arms. CNT counts acknowledged codes modulo 256.
// Optional feature macro: ENC_DEBOUNCE_EN. When defined, a capture needs
// DB_CYCLES consecutive edges sampling the same non-zero IN with G=1.
module encoder_8_to_3_seq #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       G,
  input  logic [7:0] IN,
  output logic [2:0] OUT,
  output logic       VALID,
  input  logic       ACK,
  output logic [7:0] CNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic       capture_c;
  logic [2:0] enc_c;

  // Elaboration guard on the debounce length
  if (DB_CYCLES < 2 || DB_CYCLES > 15) begin : g_bad_db_cycles
    $error("encoder_8_to_3_seq: DB_CYCLES must be in 2..15");
  end

  // Index of the highest set bit; bit 7 wins
  function automatic logic [2:0] hi_index(input logic [7:0] v);
    hi_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) hi_index = 3'(i);
    end
  endfunction

  assign enc_c = hi_index(IN);

`ifdef ENC_DEBOUNCE_EN
  localparam logic [3:0] DB_LIMIT = 4'(DB_CYCLES);

  logic [7:0] db_sample;
  logic [3:0] db_count;
  logic [3:0] db_count_nxt_c;

  // Stability count: consecutive identical non-zero samples with G=1 while idle
  always_comb begin
    db_count_nxt_c = 4'd0;
    if (state == ST_IDLE && G && IN != 8'd0) begin
      if (db_count != 4'd0 && IN == db_sample) begin
        db_count_nxt_c = db_count + 4'd1;
      end else begin
        db_count_nxt_c = 4'd1;
      end
    end
    capture_c = (state == ST_IDLE) && (db_count_nxt_c == DB_LIMIT);
  end

  // Debounce sample register and stability counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_sample <= 8'd0;
      db_count  <= 4'd0;
    end else begin
      db_sample <= IN;
      db_count  <= capture_c ? 4'd0 : db_count_nxt_c;
    end
  end
`else
  // Capture on any non-zero request sampled with G=1 while idle
  always_comb begin
    capture_c = (state == ST_IDLE) && G && (IN != 8'd0);
  end
`endif

  // Capture / hold / release sequencing with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      OUT   <= 3'd0;
      VALID <= 1'b0;
      CNT   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture_c) begin
            OUT   <= enc_c;
            VALID <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ACK) begin
            VALID <= 1'b0;
            CNT   <= CNT + 8'd1;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!G || IN == 8'd0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
